// File: rtl/soc_control_module_pkg.sv
// Shared opcodes, FSM states and widths for the SOC debug controller.
// Defining SOC_CM_DUMP_EN widens cmd_op and adds the DUMP opcode.
package soc_control_module_pkg;

`ifdef SOC_CM_DUMP_EN
  localparam int CM_OP_WIDTH = 3;
`else
  localparam int CM_OP_WIDTH = 2;
`endif

  localparam logic [CM_OP_WIDTH-1:0] CM_OP_HALT   = CM_OP_WIDTH'(0);
  localparam logic [CM_OP_WIDTH-1:0] CM_OP_RESUME = CM_OP_WIDTH'(1);
  localparam logic [CM_OP_WIDTH-1:0] CM_OP_READ   = CM_OP_WIDTH'(2);
  localparam logic [CM_OP_WIDTH-1:0] CM_OP_WRITE  = CM_OP_WIDTH'(3);
`ifdef SOC_CM_DUMP_EN
  localparam logic [CM_OP_WIDTH-1:0] CM_OP_DUMP   = CM_OP_WIDTH'(4);
`endif

  localparam logic [4:0] CM_DUMP_LAST = 5'd31;

  typedef enum logic [2:0] {
    CM_IDLE,
    CM_STOPPING,
    CM_READ,
    CM_READ_CAP,
    CM_WRITE,
    CM_WRITE_END,
    CM_RESP
  } cm_state_e;

endpackage

// File: rtl/soc_control_module_stop_sync.sv
// Negedge-registered core clock gate plus settle counter and halted status.
// Uses no optional macros.
module cm_stop_sync #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic stop_req,
  input  logic resume,
  output logic cm_cpu_stop,
  output logic halted
);

  localparam int CW = $clog2(SETTLE_CYCLES + 2);

  logic          stop_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          halted_q, halted_d;

  // Falling-edge flop: the gate only moves while clk is low.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) stop_q <= 1'b0;
    else     stop_q <= stop_req;
  end

  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    halted_d = halted_q;
    if (resume || !stop_req) begin
      cnt_d    = '0;
      run_d    = 1'b0;
      halted_d = 1'b0;
    end else if (stop_q && !halted_q) begin
      if (!run_q) begin
        run_d = 1'b1;
        cnt_d = CW'(SETTLE_CYCLES);
      end else if (cnt_q == '0) begin
        run_d    = 1'b0;
        halted_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      halted_q <= halted_d;
    end
  end

  assign cm_cpu_stop = stop_q;
  assign halted      = halted_q;

endmodule

// File: rtl/soc_control_module.sv
// Host debug controller: halt/resume and register-file access on a stopped core.
// SOC_CM_DUMP_EN adds a 32-beat register dump command.
module soc_control_module
  import soc_control_module_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CM_OP_WIDTH-1:0]    cmd_op,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err,
  output logic                      cm_cpu_stop,
  output logic [REG_ADDR_WIDTH-1:0] cm_read_write_regfile_addr,
  output logic [DATA_WIDTH-1:0]     cm_write_regfile_dat,
  output logic                      cm_write_regfile_enb,
  input  logic [DATA_WIDTH-1:0]     cm_read_regfile_dat,
  output logic                      halted
);

  cm_state_e                 state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      stop_req_q, stop_req_d;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]     rf_wdat_q, rf_wdat_d;
  logic                      rf_we_q, rf_we_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
`ifdef SOC_CM_DUMP_EN
  logic                      dump_q, dump_d;
  logic [4:0]                beat_q, beat_d;
`endif

  logic cmd_fire, rsp_fire, resume;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign rsp_fire = rsp_valid_q && rsp_ready;
  assign resume   = cmd_fire && (cmd_op == CM_OP_RESUME) && halted;

  cm_stop_sync #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_stop_sync (
    .clk         (clk),
    .rst         (rst),
    .stop_req    (stop_req_q),
    .resume      (resume),
    .cm_cpu_stop (cm_cpu_stop),
    .halted      (halted)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    stop_req_d  = stop_req_q;
    rf_addr_d   = rf_addr_q;
    rf_wdat_d   = rf_wdat_q;
    rf_we_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef SOC_CM_DUMP_EN
    dump_d      = dump_q;
    beat_d      = beat_q;
`endif
    unique case (state_q)
      CM_IDLE: begin
        if (cmd_fire) begin
          addr_d      = cmd_addr;
          data_d      = cmd_data;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          state_d     = CM_RESP;
          rsp_valid_d = 1'b1;
          case (cmd_op)
            CM_OP_HALT: begin
              if (!halted) begin
                stop_req_d  = 1'b1;
                state_d     = CM_STOPPING;
                rsp_valid_d = 1'b0;
              end
            end
            CM_OP_RESUME: stop_req_d = 1'b0;
            CM_OP_READ: begin
              if (halted) begin
                state_d     = CM_READ;
                rsp_valid_d = 1'b0;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            CM_OP_WRITE: begin
              if (halted && cmd_addr != '0) begin
                state_d     = CM_WRITE;
                rsp_valid_d = 1'b0;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
`ifdef SOC_CM_DUMP_EN
            CM_OP_DUMP: begin
              if (halted) begin
                dump_d      = 1'b1;
                beat_d      = '0;
                state_d     = CM_READ;
                rsp_valid_d = 1'b0;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
`endif
            default: rsp_err_d = 1'b1;
          endcase
        end
      end
      CM_STOPPING: begin
        if (halted) begin
          state_d     = CM_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      CM_READ: begin
`ifdef SOC_CM_DUMP_EN
        rf_addr_d = dump_q ? REG_ADDR_WIDTH'(beat_q) : addr_q;
`else
        rf_addr_d = addr_q;
`endif
        state_d = CM_READ_CAP;
      end
      CM_READ_CAP: begin
        rsp_data_d  = cm_read_regfile_dat;
        rsp_valid_d = 1'b1;
        state_d     = CM_RESP;
      end
      CM_WRITE: begin
        rf_addr_d = addr_q;
        rf_wdat_d = data_q;
        rf_we_d   = 1'b1;
        state_d   = CM_WRITE_END;
      end
      CM_WRITE_END: begin
        rsp_valid_d = 1'b1;
        state_d     = CM_RESP;
      end
      CM_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          state_d     = CM_IDLE;
`ifdef SOC_CM_DUMP_EN
          if (dump_q && beat_q != CM_DUMP_LAST) begin
            beat_d  = beat_q + 1'b1;
            state_d = CM_READ;
          end else begin
            dump_d = 1'b0;
          end
`endif
        end
      end
      default: state_d = CM_IDLE;
    endcase
    cmd_ready_d = (state_d == CM_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CM_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      stop_req_q  <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdat_q   <= '0;
      rf_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef SOC_CM_DUMP_EN
      dump_q      <= 1'b0;
      beat_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      stop_req_q  <= stop_req_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdat_q   <= rf_wdat_d;
      rf_we_q     <= rf_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef SOC_CM_DUMP_EN
      dump_q      <= dump_d;
      beat_q      <= beat_d;
`endif
    end
  end

  assign cmd_ready                  = cmd_ready_q;
  assign rsp_valid                  = rsp_valid_q;
  assign rsp_data                   = rsp_data_q;
  assign rsp_err                    = rsp_err_q;
  assign cm_read_write_regfile_addr = rf_addr_q;
  assign cm_write_regfile_dat       = rf_wdat_q;
  assign cm_write_regfile_enb       = rf_we_q;

endmodule

// File: tb/tb_soc_control_module.sv
// Scoreboard bench for soc_control_module with a behavioural register file.
// Covers SOC_CM_DUMP_EN when that macro is defined.
module tb_soc_control_module;
  import soc_control_module_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid, cmd_ready;
  logic [CM_OP_WIDTH-1:0] cmd_op;
  logic [AW-1:0]          cmd_addr;
  logic [DW-1:0]          cmd_data;
  logic                   rsp_valid, rsp_ready;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_err;
  logic                   cm_cpu_stop;
  logic [AW-1:0]          rf_addr;
  logic [DW-1:0]          rf_wdat;
  logic                   rf_we;
  logic [DW-1:0]          rf_rdat;
  logic                   halted;

  always #5 clk = ~clk;

  soc_control_module #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .SETTLE_CYCLES(2)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .cmd_valid                  (cmd_valid),
    .cmd_ready                  (cmd_ready),
    .cmd_op                     (cmd_op),
    .cmd_addr                   (cmd_addr),
    .cmd_data                   (cmd_data),
    .rsp_valid                  (rsp_valid),
    .rsp_ready                  (rsp_ready),
    .rsp_data                   (rsp_data),
    .rsp_err                    (rsp_err),
    .cm_cpu_stop                (cm_cpu_stop),
    .cm_read_write_regfile_addr (rf_addr),
    .cm_write_regfile_dat       (rf_wdat),
    .cm_write_regfile_enb       (rf_we),
    .cm_read_regfile_dat        (rf_rdat),
    .halted                     (halted)
  );

  // Core register file and gated core clock
  logic [DW-1:0] rf [32] = '{default: '0};
  assign rf_rdat = rf[rf_addr];
  always @(posedge clk) if (rf_we === 1'b1) rf[rf_addr] <= rf_wdat;

  logic gclk;
  assign gclk = clk & ~cm_cpu_stop;
  int g_cnt = 0;
  always @(posedge gclk) g_cnt++;

  int wr_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  always @(negedge clk) if (rf_we === 1'b1) begin
    wr_cnt++;
    wr_addr = rf_addr;
  end

  int viol = 0;
  always @(cm_cpu_stop) if (clk === 1'b1 && rst === 1'b0) viol++;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic e, input int lat);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.lat  = lat;
    sb.push_back(x);
  endtask

  task automatic send(input logic [CM_OP_WIDTH-1:0] op,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit rdy;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    for (int i = 0; i < 50; i++) begin
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1 cmd_valid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int   lat;
    exp_t x;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (rsp_valid !== 1'b1 || sb.size() == 0) return;
    x = sb.pop_front();
    chk({tag, "_data"}, 64'(rsp_data), 64'(x.data));
    chk({tag, "_err"}, 64'(rsp_err), 64'(x.err));
    if (x.lat >= 0) chk({tag, "_lat"}, 64'(lat), 64'(x.lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_v"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_d"}, 64'(rsp_data), 64'(x.data));
      chk({tag, "_hold_rdy"}, 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic [CM_OP_WIDTH-1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] ed,
                      input logic ee, input int lat, input string tag);
    push(ed, ee, lat);
    send(op, a, d);
    get_rsp(tag, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int            w0, g0;
  logic [AW-1:0] a0;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_stop", 64'(cm_cpu_stop), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_addr", 64'(rf_addr), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_ready", 64'(cmd_ready), 64'd1);

    w0 = wr_cnt;
    a0 = rf_addr;
    xact(CM_OP_READ, 5'd3, '0, '0, 1'b1, -1, "rd_running");
    chk("rd_running_addr", 64'(rf_addr), 64'(a0));
    chk("rd_running_we", 64'(wr_cnt - w0), 64'd0);
    chk("rd_running_stop", 64'(cm_cpu_stop), 64'd0);
    xact(CM_OP_RESUME, '0, '0, '0, 1'b0, -1, "resume_running");

    xact(CM_OP_HALT, '0, '0, '0, 1'b0, -1, "halt");
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_stop", 64'(cm_cpu_stop), 64'd1);
    g0 = g_cnt;
    repeat (5) @(posedge clk);
    #1 chk("gclk_halted", 64'(g_cnt - g0), 64'd0);

    w0 = wr_cnt;
    xact(CM_OP_WRITE, 5'd5, 32'hDEADBEEF, '0, 1'b0, 2, "wr5");
    chk("wr5_strobes", 64'(wr_cnt - w0), 64'd1);
    chk("wr5_addr", 64'(wr_addr), 64'd5);
    chk("wr5_rf", 64'(rf[5]), 64'hDEADBEEF);
    xact(CM_OP_READ, 5'd5, '0, 32'hDEADBEEF, 1'b0, 2, "rd5");

    w0 = wr_cnt;
    xact(CM_OP_WRITE, 5'd0, 32'h1, '0, 1'b1, -1, "wr0");
    chk("wr0_strobes", 64'(wr_cnt - w0), 64'd0);

    push('0, 1'b0, -1);
    send(CM_OP_HALT, '0, '0);
    get_rsp("halt_stall", 10);
    #1 chk("stall_idle", 64'(cmd_ready), 64'd1);

`ifdef SOC_CM_DUMP_EN
    for (int n = 1; n < 32; n++)
      xact(CM_OP_WRITE, AW'(n), DW'(n * 4), '0, 1'b0, 2, "preload");
    for (int n = 0; n < 32; n++) push(DW'(n * 4), 1'b0, -1);
    send(CM_OP_DUMP, '0, '0);
    for (int n = 0; n < 32; n++) get_rsp("dump", 0);
    repeat (3) @(posedge clk);
    #1 chk("dump_end", 64'(rsp_valid), 64'd0);
`endif

    push('0, 1'b0, -1);
    send(CM_OP_RESUME, '0, '0);
    chk("resume_halted_clr", 64'(halted), 64'd0);
    chk("resume_stop_held", 64'(cm_cpu_stop), 64'd1);
    get_rsp("resume", 0);
    @(negedge clk);
    #1 chk("resume_stop", 64'(cm_cpu_stop), 64'd0);
    g0 = g_cnt;
    repeat (5) @(posedge clk);
    #1 chk("gclk_running", 64'(g_cnt - g0), 64'd5);

`ifdef SOC_CM_DUMP_EN
    xact(CM_OP_DUMP, '0, '0, '0, 1'b1, -1, "dump_running");
    repeat (3) @(posedge clk);
    #1 chk("dump_running_end", 64'(rsp_valid), 64'd0);
`endif

    push('0, 1'b0, -1);
    send(CM_OP_HALT, '0, '0);
    @(posedge clk);
    #1 chk("stopping_stop", 64'(cm_cpu_stop), 64'd1);
    #2 rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    chk("midrst_stop", 64'(cm_cpu_stop), 64'd0);
    chk("midrst_halted", 64'(halted), 64'd0);
    chk("midrst_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    xact(CM_OP_RESUME, '0, '0, '0, 1'b0, -1, "post_rst");

    chk("stop_edge_viol", 64'(viol), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
